// File: rtl/riscv_pkg.sv
// Shared constants for the multicycle RISC-V control unit: opcodes,
// immediate/RF-input select codes, FSM state encodings and fault codes.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RFIN_ALU = 2'b00;
  localparam logic [1:0] RFIN_DM  = 2'b01;
  localparam logic [1:0] RFIN_PC  = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_FAULT  = 3'd5;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_IM_TO   = 2'b10;
  localparam logic [1:0] FC_DM_TO   = 2'b11;

  // True for every opcode the control unit knows how to sequence.
  function automatic logic opcode_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_branch_resolve.sv
// Branch condition resolution: picks the ALU compare flag named by func3.
module branch_resolve
  import riscv_pkg::*;
(
  input  logic [2:0] func3,
  input  logic [5:0] flags,   // {bgeu,bltu,bge,blt,bne,beq}
  output logic       taken,
  output logic       illegal
);

  // Select the flag; reserved func3 encodings are illegal and never taken.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (func3)
      F3_BEQ:  taken = flags[0];
      F3_BNE:  taken = flags[1];
      F3_BLT:  taken = flags[2];
      F3_BGE:  taken = flags[3];
      F3_BLTU: taken = flags[4];
      F3_BGEU: taken = flags[5];
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control unit for the 64-bit RISC-V datapath. Sequences
// FETCH/DECODE/EXEC/MEM/WB, drives all datapath enables and selects, and
// latches a sticky fault on illegal opcodes or memory handshake timeouts.
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [5:0] flags,
  input  logic       im_ready,
  input  logic       dm_ready,
  output logic       im_req,
  output logic       dm_req,
  output logic       dm_we,
  output logic       load_IR,
  output logic       load_PC,
  output logic       we_RF,
  output logic       sel_ALU_A,
  output logic       sel_ALU_B,
  output logic       sel_PC_A,
  output logic       sel_PC_B,
  output logic       sel_PC_RF,
  output logic [2:0] sel_imme,
  output logic [1:0] sel_RF_in,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] wait_cnt;
  logic [1:0]  fc_next;
  logic        fault_q;
  logic [1:0]  fault_code_q;
  logic        br_taken, br_illegal;
  logic        is_store;

  assign is_store   = (opcode == OP_STORE);
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

  branch_resolve u_branch_resolve (
    .func3   (func3),
    .flags   (flags),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  // Next-state and fault-code decision; ready beats a same-cycle timeout.
  always_comb begin
    state_next = state;
    fc_next    = FC_NONE;
    case (state)
      S_FETCH: begin
        if (im_ready) begin
          state_next = S_DECODE;
        end else if (wait_cnt == CNT_LAST) begin
          state_next = S_FAULT;
          fc_next    = FC_IM_TO;
        end
      end
      S_DECODE: begin
        if (opcode_supported(opcode)) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_FAULT;
          fc_next    = FC_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEM;
          OP_BRANCH: begin
            if (br_illegal) begin
              state_next = S_FAULT;
              fc_next    = FC_ILLEGAL;
            end else begin
              state_next = S_FETCH;
            end
          end
          OP_R, OP_I, OP_AUIPC, OP_JAL, OP_JALR: state_next = S_FETCH;
          default: begin
            state_next = S_FAULT;
            fc_next    = FC_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        if (dm_ready) begin
          state_next = is_store ? S_FETCH : S_WB;
        end else if (wait_cnt == CNT_LAST) begin
          state_next = S_FAULT;
          fc_next    = FC_DM_TO;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FETCH;
    endcase
  end

  // State register, handshake wait counter and sticky fault capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if ((state == S_FETCH && !im_ready) || (state == S_MEM && !dm_ready)) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (state_next == S_FAULT && state != S_FAULT) begin
        fault_q      <= 1'b1;
        fault_code_q <= fc_next;
      end
    end
  end

  // Moore outputs per state, gated to defaults while reset is asserted.
  // MEM reuses the LOAD/STORE address selects from EXEC; IR is stable there.
  always_comb begin
    im_req    = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    load_IR   = 1'b0;
    load_PC   = 1'b0;
    we_RF     = 1'b0;
    sel_ALU_A = 1'b1;
    sel_ALU_B = 1'b1;
    sel_PC_A  = 1'b1;
    sel_PC_B  = 1'b1;
    sel_PC_RF = 1'b1;
    sel_imme  = IMM_I;
    sel_RF_in = RFIN_ALU;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          im_req  = 1'b1;
          load_IR = im_ready;
        end
        S_EXEC: begin
          case (opcode)
            OP_R: begin
              we_RF   = 1'b1;
              load_PC = 1'b1;
            end
            OP_I: begin
              sel_ALU_B = 1'b0;
              we_RF     = 1'b1;
              load_PC   = 1'b1;
            end
            OP_AUIPC: begin
              sel_imme  = IMM_U;
              sel_PC_RF = 1'b0;
              sel_RF_in = RFIN_PC;
              we_RF     = 1'b1;
              load_PC   = 1'b1;
            end
            OP_JAL: begin
              sel_imme  = IMM_J;
              sel_PC_B  = 1'b0;
              sel_RF_in = RFIN_PC;
              we_RF     = 1'b1;
              load_PC   = 1'b1;
            end
            OP_JALR: begin
              sel_imme  = IMM_I;
              sel_PC_A  = 1'b0;
              sel_PC_B  = 1'b0;
              sel_RF_in = RFIN_PC;
              we_RF     = 1'b1;
              load_PC   = 1'b1;
            end
            OP_BRANCH: begin
              sel_imme = IMM_B;
              sel_PC_B = !br_taken;
              load_PC  = !br_illegal;
            end
            OP_LOAD: begin
              sel_ALU_B = 1'b0;
              sel_imme  = IMM_I;
            end
            OP_STORE: begin
              sel_ALU_B = 1'b0;
              sel_imme  = IMM_S;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          sel_ALU_B = 1'b0;
          sel_imme  = is_store ? IMM_S : IMM_I;
          dm_req    = 1'b1;
          dm_we     = is_store;
          load_PC   = is_store && dm_ready;
        end
        S_WB: begin
          sel_RF_in = RFIN_DM;
          we_RF     = 1'b1;
          load_PC   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
